// File: rtl/pic16_decoder.sv
// ----------------------------------------------------------------------------
// pic16_decoder
//   Fetch / decode / sequencing front end of the PIC16 core. Holds the program
//   counter, a one-deep instruction register and the circular hardware call
//   stack, and turns the current 14-bit instruction into the ALU opcode bus
//   and the W / file / status write strobes. One instruction per clock; skips
//   and taken branches invalidate the word fetched in parallel (one bubble).
//
// Ports
//   clk_i       clock, all state on the rising edge
//   rst_i       synchronous reset, active high
//   pm_data_i   program memory word at address pc_o (valid same cycle)
//   pclath_i    PCLATH[4:3], upper target bits for CALL/GOTO
//   z_i         ALU zero flag for the instruction being decoded
//   wake_i      wake request while asleep
//   pc_o        program memory address
//   cb_o        ALU operation code
//   b_o         bit position (IR[9:7])
//   f_addr_o    file register address (IR[6:0])
//   k_o         literal (IR[7:0])
//   k_sel_o     1: ALU operand from literal, 0: from file bus
//   alu_we_o    W write enable
//   f_we_o      file register write enable
//   flag_we_o   {C,DC,Z} status write enables
//   gie_set_o   one-cycle pulse on RETFIE
//   wdt_clr_o   one-cycle pulse on CLRWDT
//   asleep_o    core is in SLEEP
//
// States
//   S_FILL  | IR holds no valid instruction, first fetch after reset / wake
//   S_RUN   | normal execution, IR valid unless a bubble is pending
//   S_SLEEP | PC and IR frozen, waiting for wake_i
// ----------------------------------------------------------------------------
module pic16_decoder #(
    parameter int PC_W  = 13,
    parameter int STK_D = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [13:0]     pm_data_i,
    input  logic [1:0]      pclath_i,
    input  logic            z_i,
    input  logic            wake_i,
    output logic [PC_W-1:0] pc_o,
    output logic [4:0]      cb_o,
    output logic [2:0]      b_o,
    output logic [6:0]      f_addr_o,
    output logic [7:0]      k_o,
    output logic            k_sel_o,
    output logic            alu_we_o,
    output logic            f_we_o,
    output logic [2:0]      flag_we_o,
    output logic            gie_set_o,
    output logic            wdt_clr_o,
    output logic            asleep_o
);

    localparam int SP_W = (STK_D > 1) ? $clog2(STK_D) : 1;

    // ALU operation codes, same encoding the ALU consumes
    localparam logic [4:0] OP_IPSF  = 5'd0;
    localparam logic [4:0] OP_IPSW  = 5'd1;
    localparam logic [4:0] OP_IADD  = 5'd2;
    localparam logic [4:0] OP_ISUB  = 5'd3;
    localparam logic [4:0] OP_IAND  = 5'd4;
    localparam logic [4:0] OP_IOR   = 5'd5;
    localparam logic [4:0] OP_IXOR  = 5'd6;
    localparam logic [4:0] OP_INTF  = 5'd7;
    localparam logic [4:0] OP_ICLR  = 5'd8;
    localparam logic [4:0] OP_IINC1 = 5'd9;
    localparam logic [4:0] OP_IINC2 = 5'd10;
    localparam logic [4:0] OP_IDEC1 = 5'd11;
    localparam logic [4:0] OP_IDEC2 = 5'd12;
    localparam logic [4:0] OP_IRRF  = 5'd13;
    localparam logic [4:0] OP_IRLF  = 5'd14;
    localparam logic [4:0] OP_ISWP  = 5'd15;
    localparam logic [4:0] OP_IBCF  = 5'd16;
    localparam logic [4:0] OP_IBSF  = 5'd17;
    localparam logic [4:0] OP_IBTF  = 5'd18;

    localparam logic [2:0] FL_NONE = 3'b000;
    localparam logic [2:0] FL_Z    = 3'b001;
    localparam logic [2:0] FL_C    = 3'b100;
    localparam logic [2:0] FL_ALL  = 3'b111;

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_SLEEP = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [13:0]     ir_q, ir_d;
    logic            ir_v_q, ir_v_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic [PC_W-1:0] stack_q [STK_D];

    logic            exec;
    logic [4:0]      dec_cb;
    logic            dec_k_sel, dec_alu_we, dec_f_we;
    logic [2:0]      dec_flag_we;
    logic            dec_gie, dec_wdt;
    logic            dec_skip_z1, dec_skip_z0;
    logic            dec_goto, dec_call, dec_ret, dec_sleep;
    logic            skip;
    logic            push;
    logic [SP_W-1:0] sp_dec;
    logic [PC_W-1:0] jmp_tgt;

    assign exec    = (state_q == S_RUN) && ir_v_q;
    assign sp_dec  = sp_q - SP_W'(1);
    assign jmp_tgt = PC_W'({pclath_i, ir_q[10:0]});
    assign skip    = (dec_skip_z1 && z_i) || (dec_skip_z0 && !z_i);

    // Instruction decode; anything not executing decodes as a NOP
    always_comb begin
        dec_cb      = OP_IPSF;
        dec_k_sel   = 1'b0;
        dec_alu_we  = 1'b0;
        dec_f_we    = 1'b0;
        dec_flag_we = FL_NONE;
        dec_gie     = 1'b0;
        dec_wdt     = 1'b0;
        dec_skip_z1 = 1'b0;
        dec_skip_z0 = 1'b0;
        dec_goto    = 1'b0;
        dec_call    = 1'b0;
        dec_ret     = 1'b0;
        dec_sleep   = 1'b0;
        if (exec) begin
            unique case (ir_q[13:12])
                2'b00: begin
                    case (ir_q[11:8])
                        4'h0: begin
                            if (ir_q[7]) begin
                                dec_cb   = OP_IPSW;
                                dec_f_we = 1'b1;
                            end else begin
                                case (ir_q[6:0])
                                    7'h08: dec_ret = 1'b1;
                                    7'h09: begin
                                        dec_ret = 1'b1;
                                        dec_gie = 1'b1;
                                    end
                                    7'h63: dec_sleep = 1'b1;
                                    7'h64: dec_wdt   = 1'b1;
                                    default: ;
                                endcase
                            end
                        end
                        4'h1: begin
                            dec_cb      = OP_ICLR;
                            dec_flag_we = FL_Z;
                            dec_alu_we  = ~ir_q[7];
                            dec_f_we    = ir_q[7];
                        end
                        default: begin
                            // byte ops: d selects W or file destination
                            dec_alu_we = ~ir_q[7];
                            dec_f_we   = ir_q[7];
                            case (ir_q[11:8])
                                4'h2: begin dec_cb = OP_ISUB;  dec_flag_we = FL_ALL; end
                                4'h3: begin dec_cb = OP_IDEC1; dec_flag_we = FL_Z;   end
                                4'h4: begin dec_cb = OP_IOR;   dec_flag_we = FL_Z;   end
                                4'h5: begin dec_cb = OP_IAND;  dec_flag_we = FL_Z;   end
                                4'h6: begin dec_cb = OP_IXOR;  dec_flag_we = FL_Z;   end
                                4'h7: begin dec_cb = OP_IADD;  dec_flag_we = FL_ALL; end
                                4'h8: begin dec_cb = OP_IPSF;  dec_flag_we = FL_Z;   end
                                4'h9: begin dec_cb = OP_INTF;  dec_flag_we = FL_Z;   end
                                4'hA: begin dec_cb = OP_IINC1; dec_flag_we = FL_Z;   end
                                4'hB: begin dec_cb = OP_IDEC2; dec_skip_z1 = 1'b1;   end
                                4'hC: begin dec_cb = OP_IRRF;  dec_flag_we = FL_C;   end
                                4'hD: begin dec_cb = OP_IRLF;  dec_flag_we = FL_C;   end
                                4'hE: begin dec_cb = OP_ISWP;                        end
                                default: begin dec_cb = OP_IINC2; dec_skip_z1 = 1'b1; end
                            endcase
                        end
                    endcase
                end
                2'b01: begin
                    case (ir_q[11:10])
                        2'b00: begin dec_cb = OP_IBCF; dec_f_we = 1'b1; end
                        2'b01: begin dec_cb = OP_IBSF; dec_f_we = 1'b1; end
                        2'b10: begin dec_cb = OP_IBTF; dec_skip_z1 = 1'b1; end
                        default: begin dec_cb = OP_IBTF; dec_skip_z0 = 1'b1; end
                    endcase
                end
                2'b10: begin
                    dec_goto = ir_q[11];
                    dec_call = ~ir_q[11];
                end
                default: begin
                    dec_k_sel  = 1'b1;
                    dec_alu_we = 1'b1;
                    casez (ir_q[11:8])
                        4'b00??: dec_cb = OP_IPSF;
                        4'b01??: begin dec_cb = OP_IPSF; dec_ret = 1'b1; end
                        4'b1000: begin dec_cb = OP_IOR;  dec_flag_we = FL_Z; end
                        4'b1001: begin dec_cb = OP_IAND; dec_flag_we = FL_Z; end
                        4'b1010: begin dec_cb = OP_IXOR; dec_flag_we = FL_Z; end
                        4'b110?: begin dec_cb = OP_ISUB; dec_flag_we = FL_ALL; end
                        4'b111?: begin dec_cb = OP_IADD; dec_flag_we = FL_ALL; end
                        default: begin
                            // 0x3Bxx is unassigned: plain NOP
                            dec_k_sel  = 1'b0;
                            dec_alu_we = 1'b0;
                        end
                    endcase
                end
            endcase
        end
    end

    // Sequencing: fetch every non-sleep cycle, redirect on branch/return
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ir_v_d  = ir_v_q;
        sp_d    = sp_q;
        push    = 1'b0;
        if (state_q == S_SLEEP) begin
            if (wake_i) begin
                state_d = S_FILL;
                ir_v_d  = 1'b0;
            end
        end else if (dec_sleep) begin
            // PC already points past SLEEP; hold it so wake refetches there
            state_d = S_SLEEP;
            ir_v_d  = 1'b0;
        end else begin
            state_d = S_RUN;
            ir_d    = pm_data_i;
            ir_v_d  = 1'b1;
            pc_d    = pc_q + PC_W'(1);
            if (dec_goto || dec_call) begin
                pc_d   = jmp_tgt;
                ir_v_d = 1'b0;
                if (dec_call) begin
                    push = 1'b1;
                    sp_d = sp_q + SP_W'(1);
                end
            end else if (dec_ret) begin
                pc_d   = stack_q[sp_dec];
                sp_d   = sp_dec;
                ir_v_d = 1'b0;
            end else if (skip) begin
                ir_v_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FILL;
            pc_q    <= '0;
            ir_q    <= '0;
            ir_v_q  <= 1'b0;
            sp_q    <= '0;
            for (int i = 0; i < STK_D; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ir_v_q  <= ir_v_d;
            sp_q    <= sp_d;
            // pc_q is the return address: it already points past the CALL
            if (push) begin
                stack_q[sp_q] <= pc_q;
            end
        end
    end

    assign pc_o      = pc_q;
    assign cb_o      = dec_cb;
    assign b_o       = exec ? ir_q[9:7] : 3'd0;
    assign f_addr_o  = exec ? ir_q[6:0] : 7'd0;
    assign k_o       = exec ? ir_q[7:0] : 8'd0;
    assign k_sel_o   = dec_k_sel;
    assign alu_we_o  = dec_alu_we;
    assign f_we_o    = dec_f_we;
    assign flag_we_o = dec_flag_we;
    assign gie_set_o = dec_gie;
    assign wdt_clr_o = dec_wdt;
    assign asleep_o  = (state_q == S_SLEEP);

endmodule

// File: tb/tb_pic16_decoder.sv
// ----------------------------------------------------------------------------
// tb_pic16_decoder
//   Directed programs with hand-computed expectations, then a randomized
//   program run. A behavioural program-flow model (PC, valid flag, sleep flag,
//   mod-8 stack) predicts every output each cycle.
// ----------------------------------------------------------------------------
module tb_pic16_decoder;

    localparam logic [4:0] C_IPSF  = 5'd0;
    localparam logic [4:0] C_IPSW  = 5'd1;
    localparam logic [4:0] C_IADD  = 5'd2;
    localparam logic [4:0] C_ISUB  = 5'd3;
    localparam logic [4:0] C_IAND  = 5'd4;
    localparam logic [4:0] C_IOR   = 5'd5;
    localparam logic [4:0] C_IXOR  = 5'd6;
    localparam logic [4:0] C_INTF  = 5'd7;
    localparam logic [4:0] C_ICLR  = 5'd8;
    localparam logic [4:0] C_IINC1 = 5'd9;
    localparam logic [4:0] C_IINC2 = 5'd10;
    localparam logic [4:0] C_IDEC1 = 5'd11;
    localparam logic [4:0] C_IDEC2 = 5'd12;
    localparam logic [4:0] C_IRRF  = 5'd13;
    localparam logic [4:0] C_IRLF  = 5'd14;
    localparam logic [4:0] C_ISWP  = 5'd15;
    localparam logic [4:0] C_IBCF  = 5'd16;
    localparam logic [4:0] C_IBSF  = 5'd17;
    localparam logic [4:0] C_IBTF  = 5'd18;

    localparam logic [2:0] K_NONE  = 3'd0;
    localparam logic [2:0] K_SKIP1 = 3'd1;
    localparam logic [2:0] K_SKIP0 = 3'd2;
    localparam logic [2:0] K_GOTO  = 3'd3;
    localparam logic [2:0] K_CALL  = 3'd4;
    localparam logic [2:0] K_RET   = 3'd5;
    localparam logic [2:0] K_SLEEP = 3'd6;

    typedef struct packed {
        logic [4:0] cb;
        logic       ksel;
        logic       awe;
        logic       fwe;
        logic [2:0] flg;
        logic       gie;
        logic       wdt;
        logic [2:0] kind;
    } dec_t;

    logic        clk = 1'b0;
    logic        rst, z, wake;
    logic [1:0]  pclath;
    logic [13:0] pm_data;
    logic [12:0] pc_o;
    logic [4:0]  cb_o;
    logic [2:0]  b_o;
    logic [6:0]  f_addr_o;
    logic [7:0]  k_o;
    logic        k_sel_o, alu_we_o, f_we_o, gie_set_o, wdt_clr_o, asleep_o;
    logic [2:0]  flag_we_o;

    logic [13:0] pmem [8192];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign pm_data = pmem[pc_o];

    pic16_decoder #(.PC_W(13), .STK_D(8)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .pm_data_i (pm_data),
        .pclath_i  (pclath),
        .z_i       (z),
        .wake_i    (wake),
        .pc_o      (pc_o),
        .cb_o      (cb_o),
        .b_o       (b_o),
        .f_addr_o  (f_addr_o),
        .k_o       (k_o),
        .k_sel_o   (k_sel_o),
        .alu_we_o  (alu_we_o),
        .f_we_o    (f_we_o),
        .flag_we_o (flag_we_o),
        .gie_set_o (gie_set_o),
        .wdt_clr_o (wdt_clr_o),
        .asleep_o  (asleep_o)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] byte_cb(input logic [3:0] code);
        case (code)
            4'h2: return C_ISUB;  4'h3: return C_IDEC1; 4'h4: return C_IOR;
            4'h5: return C_IAND;  4'h6: return C_IXOR;  4'h7: return C_IADD;
            4'h8: return C_IPSF;  4'h9: return C_INTF;  4'hA: return C_IINC1;
            4'hB: return C_IDEC2; 4'hC: return C_IRRF;  4'hD: return C_IRLF;
            4'hE: return C_ISWP;  default: return C_IINC2;
        endcase
    endfunction

    function automatic logic [2:0] byte_flags(input logic [3:0] code);
        if (code == 4'h2 || code == 4'h7) return 3'b111;
        if (code == 4'hC || code == 4'hD) return 3'b100;
        if (code == 4'hB || code == 4'hE || code == 4'hF) return 3'b000;
        return 3'b001;
    endfunction

    // Instruction semantics by mnemonic
    function automatic dec_t model_decode(input logic [13:0] w);
        dec_t r;
        logic [3:0] code;
        r = '0;
        r.cb = C_IPSF;
        r.kind = K_NONE;
        code = w[11:8];
        if (w[13:12] == 2'b00) begin
            if (code >= 4'h2) begin
                r.cb = byte_cb(code);
                r.flg = byte_flags(code);
                r.awe = !w[7];
                r.fwe = w[7];
                if (code == 4'hB || code == 4'hF) r.kind = K_SKIP1;
            end else if (code == 4'h1) begin
                r.cb = C_ICLR; r.flg = 3'b001; r.awe = !w[7]; r.fwe = w[7];
            end else if (w[7]) begin
                r.cb = C_IPSW; r.fwe = 1'b1;
            end else if (w[6:0] == 7'h08) begin
                r.kind = K_RET;
            end else if (w[6:0] == 7'h09) begin
                r.kind = K_RET; r.gie = 1'b1;
            end else if (w[6:0] == 7'h63) begin
                r.kind = K_SLEEP;
            end else if (w[6:0] == 7'h64) begin
                r.wdt = 1'b1;
            end
        end else if (w[13:12] == 2'b01) begin
            case (w[11:10])
                2'd0: begin r.cb = C_IBCF; r.fwe = 1'b1; end
                2'd1: begin r.cb = C_IBSF; r.fwe = 1'b1; end
                2'd2: begin r.cb = C_IBTF; r.kind = K_SKIP1; end
                default: begin r.cb = C_IBTF; r.kind = K_SKIP0; end
            endcase
        end else if (w[13:12] == 2'b10) begin
            r.kind = w[11] ? K_GOTO : K_CALL;
        end else if (code != 4'hB) begin
            r.ksel = 1'b1;
            r.awe = 1'b1;
            if (code[3:2] == 2'b01) r.kind = K_RET;
            if (code == 4'h8) begin r.cb = C_IOR;  r.flg = 3'b001; end
            if (code == 4'h9) begin r.cb = C_IAND; r.flg = 3'b001; end
            if (code == 4'hA) begin r.cb = C_IXOR; r.flg = 3'b001; end
            if (code[3:1] == 3'b110) begin r.cb = C_ISUB; r.flg = 3'b111; end
            if (code[3:1] == 3'b111) begin r.cb = C_IADD; r.flg = 3'b111; end
        end
        return r;
    endfunction

    // Program-flow model
    logic        m_known = 1'b0;
    int          m_pc = 0;
    logic [13:0] m_ir = '0;
    logic        m_valid = 1'b0;
    logic        m_asleep = 1'b0;
    int          m_sp = 0;
    int          m_stk [8];
    dec_t        e;
    logic        ex;
    int          nxt;
    logic        nvalid;

    always @(negedge clk) begin
        ex = m_valid && !m_asleep;
        e  = model_decode(ex ? m_ir : 14'h0000);
        if (m_known) begin
            chk("pc",      int'(pc_o),      m_pc);
            chk("cb",      int'(cb_o),      int'(e.cb));
            chk("b",       int'(b_o),       ex ? int'(m_ir[9:7]) : 0);
            chk("f_addr",  int'(f_addr_o),  ex ? int'(m_ir[6:0]) : 0);
            chk("k",       int'(k_o),       ex ? int'(m_ir[7:0]) : 0);
            chk("k_sel",   int'(k_sel_o),   int'(e.ksel));
            chk("alu_we",  int'(alu_we_o),  int'(e.awe));
            chk("f_we",    int'(f_we_o),    int'(e.fwe));
            chk("flag_we", int'(flag_we_o), int'(e.flg));
            chk("gie_set", int'(gie_set_o), int'(e.gie));
            chk("wdt_clr", int'(wdt_clr_o), int'(e.wdt));
            chk("asleep",  int'(asleep_o),  int'(m_asleep));
        end
        if (rst) begin
            m_known = 1'b1; m_pc = 0; m_ir = '0; m_valid = 1'b0;
            m_asleep = 1'b0; m_sp = 0;
            for (int i = 0; i < 8; i++) m_stk[i] = 0;
        end else if (m_asleep) begin
            if (wake) begin m_asleep = 1'b0; m_valid = 1'b0; end
        end else if (ex && e.kind == K_SLEEP) begin
            m_asleep = 1'b1; m_valid = 1'b0;
        end else begin
            nxt = (m_pc + 1) % 8192;
            nvalid = 1'b1;
            if (ex) begin
                case (e.kind)
                    K_GOTO: begin
                        nxt = ((int'(pclath) << 11) | int'(m_ir[10:0])) % 8192;
                        nvalid = 1'b0;
                    end
                    K_CALL: begin
                        m_stk[m_sp] = m_pc;
                        m_sp = (m_sp + 1) % 8;
                        nxt = ((int'(pclath) << 11) | int'(m_ir[10:0])) % 8192;
                        nvalid = 1'b0;
                    end
                    K_RET: begin
                        m_sp = (m_sp + 7) % 8;
                        nxt = m_stk[m_sp];
                        nvalid = 1'b0;
                    end
                    K_SKIP1: if (z)  nvalid = 1'b0;
                    K_SKIP0: if (!z) nvalid = 1'b0;
                    default: ;
                endcase
            end
            m_ir = pmem[m_pc];
            m_pc = nxt;
            m_valid = nvalid;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [13:0] rand_instr();
        logic [13:0] specials [7];
        specials = '{14'h0000, 14'h0008, 14'h0009, 14'h0063, 14'h0064, 14'h0062, 14'h0065};
        case ($urandom_range(0, 9))
            0, 1: return {2'b00, 4'($urandom_range(1, 15)), 8'($urandom)};
            2:    return {7'b0000001, 7'($urandom)};
            3:    return {2'b01, 12'($urandom)};
            4, 5: return {2'b11, 12'($urandom)};
            6:    return {2'b10, 12'($urandom)};
            7:    return specials[$urandom_range(0, 6)];
            8:    return {6'b110100, 8'($urandom)};
            default: return 14'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; z = 1'b1; wake = 1'b0; pclath = 2'd0;
        for (int i = 0; i < 8192; i++) pmem[i] = 14'h0000;
        pmem[0]  = 14'h07A0;              // ADDWF 0x20,1
        pmem[5]  = 14'h0BA1;              // DECFSZ 0x21,1
        pmem[6]  = 14'h3055;              // MOVLW 0x55 (skipped)
        pmem[7]  = 14'h30AA;              // MOVLW 0xAA
        pmem[8]  = 14'h2810;              // GOTO 0x10
        pmem[16] = 14'h2123;              // CALL 0x123
        pmem[17] = 14'h2300;              // CALL 0x300: start of 9-deep chain
        pmem[13'h123] = 14'h0008;         // RETURN
        for (int i = 0; i < 8; i++) begin
            pmem[13'h300 + 16 * i] = 14'(14'h2000 | (13'h310 + 16 * i));
            pmem[13'h301 + 16 * i] = 14'h0008;
        end
        pmem[13'h380] = 14'h0008;

        cyc(); cyc();
        chk("rst_pc", int'(pc_o), 0);
        chk("rst_we", int'({alu_we_o, f_we_o, flag_we_o}), 0);
        chk("rst_asleep", int'(asleep_o), 0);
        rst = 1'b0;
        cyc();
        chk("addwf_pc", int'(pc_o), 1);
        chk("addwf_cb", int'(cb_o), int'(C_IADD));
        chk("addwf_we", int'({f_we_o, alu_we_o}), 2);
        chk("addwf_flags", int'(flag_we_o), 7);
        chk("addwf_faddr", int'(f_addr_o), 32'h20);
        repeat (5) cyc();
        chk("decfsz_pc", int'(pc_o), 6);
        chk("decfsz_cb", int'(cb_o), int'(C_IDEC2));
        cyc();
        chk("skip_bubble_cb", int'(cb_o), int'(C_IPSF));
        chk("skip_bubble_we", int'(alu_we_o), 0);
        cyc();
        chk("after_skip_pc", int'(pc_o), 8);
        chk("after_skip_k", int'(k_o), 32'hAA);
        chk("after_skip_ksel", int'(k_sel_o), 1);
        repeat (3) cyc();
        chk("call_exec_pc", int'(pc_o), 32'h11);
        cyc();
        chk("call_target", int'(pc_o), 32'h123);
        repeat (2) cyc();
        chk("return_pc", int'(pc_o), 32'h11);

        for (int i = 0; i < 400 && pc_o != 13'h302; i++) cyc();
        chk("nest_reach_302", int'(pc_o), 32'h302);
        cyc();
        chk("nest_wrap_pc", int'(pc_o), 32'h371);

        // Sleep / wake / reset-in-sleep program
        rst = 1'b1;
        for (int i = 0; i < 8192; i++) pmem[i] = 14'h0000;
        pmem[3] = 14'h0063;               // SLEEP
        pmem[4] = 14'h3012;               // MOVLW 0x12
        pmem[5] = 14'h2803;               // GOTO 3
        cyc();
        chk("rst2_pc", int'(pc_o), 0);
        rst = 1'b0;
        cyc();
        chk("rst2_next_pc", int'(pc_o), 1);
        chk("rst2_asleep", int'(asleep_o), 0);
        repeat (4) cyc();
        chk("sleep_asleep", int'(asleep_o), 1);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("sleep_hold_pc", int'(pc_o), 4);
            chk("sleep_hold_asleep", int'(asleep_o), 1);
        end
        wake = 1'b1;
        cyc();
        wake = 1'b0;
        chk("wake_asleep", int'(asleep_o), 0);
        chk("wake_pc", int'(pc_o), 4);
        cyc();
        chk("wake_fetch_k", int'(k_o), 32'h12);
        chk("wake_fetch_ksel", int'(k_sel_o), 1);
        repeat (4) cyc();
        chk("resleep", int'(asleep_o), 1);
        rst = 1'b1; wake = 1'b1;
        cyc();
        rst = 1'b0; wake = 1'b0;
        chk("rst_in_sleep_pc", int'(pc_o), 0);
        chk("rst_in_sleep_asleep", int'(asleep_o), 0);

        // Randomized program and inputs
        rst = 1'b1;
        for (int i = 0; i < 8192; i++) pmem[i] = rand_instr();
        cyc();
        rst = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            z      = 1'($urandom_range(0, 1));
            pclath = 2'($urandom);
            wake   = ($urandom_range(0, 5) == 0);
            rst    = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 1'b0; wake = 1'b0;
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
